// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative radix-2 multiply/divide unit.
//
// One shift-add (multiply) or restoring shift-subtract (divide) step is
// taken per cycle on operand magnitudes; the sign is fixed up on the last
// step. Divide-by-zero, signed overflow and unlisted opcodes skip the
// iteration and complete in a single cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     request present              in_ready   unit idle, can accept
//   a, b         operands (XLEN)              alu_control  6-bit opcode
//   flush        kill operation in flight
//   out_valid    result/zero valid            out_ready  consumer takes result
//   result       XLEN result                  zero       result == 0
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// BUSY  | one iteration step per cycle, XLEN steps total
// DONE  | result held until out_ready or flush

module muldiv_iter #(
  parameter int XLEN       = 32,
  parameter bit RISCV_DIV0 = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [5:0]      alu_control,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [5:0] OP_MUL    = 6'b000110;
  localparam logic [5:0] OP_MULH   = 6'b000111;
  localparam logic [5:0] OP_MULHSU = 6'b001000;
  localparam logic [5:0] OP_MULHU  = 6'b001001;
  localparam logic [5:0] OP_DIV    = 6'b001010;
  localparam logic [5:0] OP_DIVU   = 6'b001011;
  localparam logic [5:0] OP_REM    = 6'b001100;
  localparam logic [5:0] OP_REMU   = 6'b001101;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  // Multiply: {product high, multiplier/product low}.
  // Divide:   {partial remainder, dividend/quotient}.
  logic [2*XLEN-1:0]   acc_q, acc_d;
  // Multiplicand magnitude or divisor magnitude.
  logic [XLEN-1:0]     opb_q, opb_d;
  logic                is_div_q, is_div_d;
  // High half for multiply, remainder for divide.
  logic                sel_q, sel_d;
  logic                neg_q, neg_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                zero_q, zero_d;

  // Request decode
  logic            op_mul, op_div, op_sel, sgn_a, sgn_b;
  logic            a_neg, b_neg, b_zero, ovf, short_path;
  logic [XLEN-1:0] a_mag, b_mag, short_res;

  always_comb begin
    op_mul = 1'b0;
    op_div = 1'b0;
    op_sel = 1'b0;
    sgn_a  = 1'b0;
    sgn_b  = 1'b0;
    case (alu_control)
      OP_MUL:    op_mul = 1'b1;
      OP_MULH:   begin op_mul = 1'b1; op_sel = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      OP_MULHSU: begin op_mul = 1'b1; op_sel = 1'b1; sgn_a = 1'b1; end
      OP_MULHU:  begin op_mul = 1'b1; op_sel = 1'b1; end
      OP_DIV:    begin op_div = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      OP_DIVU:   op_div = 1'b1;
      OP_REM:    begin op_div = 1'b1; op_sel = 1'b1; sgn_a = 1'b1; sgn_b = 1'b1; end
      OP_REMU:   begin op_div = 1'b1; op_sel = 1'b1; end
      default:   ;
    endcase
  end

  always_comb begin
    a_neg  = sgn_a & a[XLEN-1];
    b_neg  = sgn_b & b[XLEN-1];
    // Negating the signed minimum yields itself, which is the correct
    // unsigned magnitude.
    a_mag  = a_neg ? -a : a;
    b_mag  = b_neg ? -b : b;
    b_zero = (b == '0);
    ovf    = op_div & sgn_b & (a == SMIN) & (b == '1);
    short_path = ~(op_mul | op_div) | (op_div & b_zero) | (RISCV_DIV0 & ovf);

    short_res = '0;
    if (!(op_mul || op_div)) begin
      short_res = '0;
    end else if (b_zero) begin
      if (RISCV_DIV0) short_res = op_sel ? a : '1;
      else            short_res = SMIN;
    end else if (ovf) begin
      short_res = op_sel ? '0 : a;
    end
  end

  // One iteration step
  logic [XLEN-1:0]   mul_addend;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    mul_addend = acc_q[0] ? opb_q : {XLEN{1'b0}};
    mul_sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    div_shift  = acc_q[2*XLEN-1:XLEN-1];
    div_diff   = div_shift - {1'b0, opb_q};
    if (is_div_q) begin
      // Borrow out of the top bit means the divisor did not fit: restore.
      if (div_diff[XLEN]) acc_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else                acc_step = {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign correction, applied to the output of the final step
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_val, div_fix, fin;

  always_comb begin
    prod_fix = neg_q ? -acc_step : acc_step;
    div_val  = sel_q ? acc_step[2*XLEN-1:XLEN] : acc_step[XLEN-1:0];
    div_fix  = neg_q ? -div_val : div_val;
    if (is_div_q) fin = div_fix;
    else          fin = sel_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    sel_d    = sel_q;
    neg_d    = neg_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          cnt_d    = '0;
          is_div_d = op_div;
          sel_d    = op_sel;
          // Remainder follows the dividend; quotient and product take the xor.
          neg_d    = (op_div && op_sel) ? a_neg : (a_neg ^ b_neg);
          if (short_path) begin
            result_d = short_res;
            zero_d   = (short_res == '0);
            state_d  = S_DONE;
          end else begin
            opb_d   = op_div ? b_mag : a_mag;
            acc_d   = {{XLEN{1'b0}}, (op_div ? a_mag : b_mag)};
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_step;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            result_d = fin;
            zero_d   = (fin == '0);
            state_d  = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (flush || out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      sel_q    <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      sel_q    <= sel_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Testbench for muldiv_iter: directed vectors, randomized ops against an
// arithmetic reference model, hold/flush/reset scenarios. A second
// instance with RISCV_DIV0=0 covers the legacy divide-by-zero result.

module tb_muldiv_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready, in_ready0;
  logic [31:0] a, b;
  logic [5:0]  alu_control;
  logic        flush;
  logic        out_valid, out_valid0;
  logic        out_ready;
  logic [31:0] result, result0;
  logic        zero, zero0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_iter #(.XLEN(32), .RISCV_DIV0(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_control(alu_control), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero)
  );

  muldiv_iter #(.XLEN(32), .RISCV_DIV0(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .a(a), .b(b), .alu_control(alu_control), .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready), .result(result0), .zero(zero0)
  );

  // Reference model: plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [5:0] op, input logic [31:0] x,
                                            input logic [31:0] y, input bit riscv);
    longint     sx, sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (op)
      6'd6:  begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      6'd7:  begin p = sx * sy; return p[63:32]; end
      6'd8:  begin p = sx * longint'({32'b0, y}); return p[63:32]; end
      6'd9:  begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      6'd10: begin
        if (y == 0) return riscv ? 32'hFFFF_FFFF : 32'h8000_0000;
        p = sx / sy; return p[31:0];
      end
      6'd11: begin
        if (y == 0) return riscv ? 32'hFFFF_FFFF : 32'h8000_0000;
        return x / y;
      end
      6'd12: begin
        if (y == 0) return riscv ? x : 32'h8000_0000;
        p = sx % sy; return p[31:0];
      end
      6'd13: begin
        if (y == 0) return riscv ? x : 32'h8000_0000;
        return x % y;
      end
      default: return 32'h0;
    endcase
  endfunction

  // Edges from the acceptance edge (inclusive) until out_valid is seen.
  function automatic int ref_lat(input logic [5:0] op, input logic [31:0] x, input logic [31:0] y);
    if (op < 6'd6 || op > 6'd13) return 1;
    if (op >= 6'd10 && y == 0) return 1;
    if ((op == 6'd10 || op == 6'd12) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; alu_control = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Issue one op from IDLE, wait (bounded) for out_valid, optionally keep
  // out_ready low for 'hold' cycles, then complete the handshake.
  task automatic run_op(input logic [5:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input int hold, output logic [31:0] res, output logic zr,
                        output int lat, output logic [31:0] res0, output bit held_ok);
    held_ok = 1'b1;
    in_valid = 1'b1; alu_control = op; a = av; b = bv;
    @(posedge clk); #1;
    lat = 1;
    in_valid = 1'b0; a = $urandom; b = $urandom; alu_control = 6'($urandom);
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result; zr = zero; res0 = result0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!out_valid || result !== res || zero !== zr) held_ok = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 00000000", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b expected 1", zero); end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [31:0] x, y, r;
    logic        z;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t vecs [11] = '{
      '{6'd6,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33},
      '{6'd9,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33},
      '{6'd7,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33},
      '{6'd8,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33},
      '{6'd10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 33},
      '{6'd12, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 33},
      '{6'd11, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b0, 1},
      '{6'd13, 32'd5,          32'd0,         32'h0000_0005, 1'b0, 1},
      '{6'd10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1},
      '{6'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1},
      '{6'd63, 32'd12,         32'd34,        32'h0000_0000, 1'b1, 1}
    };
    logic [31:0] res, res0;
    logic        zr;
    int          lat;
    bit          hk;
    do_reset();
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].x, vecs[i].y, 0, res, zr, lat, res0, hk);
      checks++; if (res !== vecs[i].r) begin errors++; $display("FAIL dir%0d_result: got %h expected %h", i, res, vecs[i].r); end
      checks++; if (zr !== vecs[i].z) begin errors++; $display("FAIL dir%0d_zero: got %b expected %b", i, zr, vecs[i].z); end
      checks++; if (lat != vecs[i].lat) begin errors++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, vecs[i].lat); end
    end
  endtask

  task automatic test_random();
    logic [31:0] res, res0, x, y, exp_r;
    logic [5:0]  op;
    logic        zr;
    int          lat, exp_l;
    bit          hk;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(6, 13));
      x = rand_operand();
      y = rand_operand();
      exp_r = ref_model(op, x, y, 1'b1);
      exp_l = ref_lat(op, x, y);
      run_op(op, x, y, $urandom_range(0, 2), res, zr, lat, res0, hk);
      checks++; if (res !== exp_r) begin errors++; $display("FAIL rnd_result op=%0d a=%h b=%h: got %h expected %h", op, x, y, res, exp_r); end
      checks++; if (zr !== (exp_r == 0)) begin errors++; $display("FAIL rnd_zero op=%0d: got %b expected %b", op, zr, (exp_r == 0)); end
      checks++; if (lat != exp_l) begin errors++; $display("FAIL rnd_latency op=%0d: got %0d expected %0d", op, lat, exp_l); end
    end
  endtask

  task automatic test_hold();
    logic [31:0] res, res0;
    logic        zr;
    int          lat;
    bit          hk;
    do_reset();
    run_op(6'd6, 32'd1234, 32'd5678, 5, res, zr, lat, res0, hk);
    checks++; if (hk !== 1'b1) begin errors++; $display("FAIL hold_stable: got %b expected 1", hk); end
    checks++; if (res !== 32'd7006652) begin errors++; $display("FAIL hold_result: got %h expected %h", res, 32'd7006652); end
  endtask

  task automatic test_flush();
    logic [31:0] res, res0, exp_r;
    logic        zr;
    int          lat, seen;
    bit          hk;
    do_reset();
    // Flush in IDLE blocks acceptance of a short-path op.
    flush = 1'b1; in_valid = 1'b1; alu_control = 6'd63; a = 32'd1; b = 32'd1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_valid: got %b expected 0", out_valid); end
    // Flush in BUSY.
    in_valid = 1'b1; alu_control = 6'd10; a = 32'd1000; b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_busy_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_busy_valid: got %b expected 0", out_valid); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_busy_late_valid: got %0d cycles expected 0", seen); end
    // Flush in DONE.
    in_valid = 1'b1; alu_control = 6'd11; a = 32'd9; b = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_done: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
    // Next op runs normally from a fresh counter.
    exp_r = ref_model(6'd13, 32'd1000, 32'd7, 1'b1);
    run_op(6'd13, 32'd1000, 32'd7, 0, res, zr, lat, res0, hk);
    checks++; if (res !== exp_r) begin errors++; $display("FAIL flush_after_result: got %h expected %h", res, exp_r); end
    checks++; if (lat != 33) begin errors++; $display("FAIL flush_after_latency: got %0d expected 33", lat); end
  endtask

  task automatic test_rst_abort();
    int seen;
    do_reset();
    in_valid = 1'b1; alu_control = 6'd6; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_abort_state: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid); end
    checks++; if (result !== 32'h0 || zero !== 1'b1) begin errors++; $display("FAIL rst_abort_result: got %h zero=%b expected 00000000 zero=1", result, zero); end
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_abort_late_valid: got %0d cycles expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res, res0, exp_r;
    logic        zr;
    int          lat;
    bit          hk;
    do_reset();
    in_valid = 1'b1; alu_control = 6'd13; a = 32'd17; b = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL b2b_done: got valid=%b ready=%b expected valid=1 ready=0", out_valid, in_ready); end
    checks++; if (result !== 32'd17) begin errors++; $display("FAIL b2b_result0: got %h expected %h", result, 32'd17); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid); end
    for (int n = 0; n < 4; n++) begin
      exp_r = ref_model(6'd7, 32'h8000_0000 + 32'(n), 32'h7FFF_FFF0 - 32'(n), 1'b1);
      run_op(6'd7, 32'h8000_0000 + 32'(n), 32'h7FFF_FFF0 - 32'(n), 0, res, zr, lat, res0, hk);
      checks++; if (res !== exp_r) begin errors++; $display("FAIL b2b_mulh%0d: got %h expected %h", n, res, exp_r); end
    end
  endtask

  task automatic test_div0();
    logic [31:0] res, res0, x, exp_r;
    logic        zr;
    int          lat;
    bit          hk;
    do_reset();
    for (int op = 10; op <= 13; op++) begin
      x = (op == 11) ? 32'd5 : $urandom;
      exp_r = ref_model(6'(op), x, 32'd0, 1'b1);
      run_op(6'(op), x, 32'd0, 0, res, zr, lat, res0, hk);
      checks++; if (res !== exp_r) begin errors++; $display("FAIL div0_riscv op=%0d: got %h expected %h", op, res, exp_r); end
      checks++; if (res0 !== ref_model(6'(op), x, 32'd0, 1'b0)) begin errors++; $display("FAIL div0_legacy op=%0d: got %h expected 80000000", op, res0); end
      checks++; if (lat != 1) begin errors++; $display("FAIL div0_latency op=%0d: got %0d expected 1", op, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_flush();
    test_rst_abort();
    test_back_to_back();
    test_random();
    test_div0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width, even, >= 8.
REQ-002 SHALL have parameter RISCV_DIV0, default 1: 1 = RISC-V divide-by-zero/overflow results, 0 = legacy divide-by-zero result {1'b1, (XLEN-1)'b0}.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1: the request is present.
REQ-007 SHALL have port in_ready, output, 1: the unit accepts a request this cycle.
REQ-008 SHALL have port a, input, XLEN: first operand (dividend/multiplicand).
REQ-009 SHALL have port b, input, XLEN: second operand (divisor/multiplier).
REQ-010 SHALL have port alu_control, input, 6: opcode; 000110 MUL, 000111 MULH, 001000 MULHSU, 001001 MULHU, 001010 DIV, 001011 DIVU, 001100 REM, 001101 REMU.
REQ-011 SHALL have port flush, input, 1: kills the operation in flight.
REQ-012 SHALL have port out_valid, output, 1: result and zero are valid.
REQ-013 SHALL have port out_ready, input, 1: the consumer takes the result.
REQ-014 SHALL have port result, output, XLEN: the operation result.
REQ-015 SHALL have port zero, output, 1: result == 0, valid whenever out_valid is high.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY and DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-017 SHALL accept a request on in_valid && in_ready; it registers a, b, opcode and sign flags, and inputs are not sampled afterwards.
REQ-018 SHALL, on acceptance of a normal op, enter BUSY with iteration counter 0.
REQ-019 SHALL execute one radix-2 step per BUSY cycle: shift-add for multiply, restoring shift-subtract for divide, on operand magnitudes.
REQ-020 SHALL, after XLEN steps, apply sign correction and enter DONE; out_valid rises exactly XLEN+1 cycles after the acceptance edge.
REQ-021 SHALL form a 2*XLEN product; MUL returns the low half; MULH/MULHSU/MULHU return the high half.
REQ-022 SHALL treat both operands as signed for MULH, a signed and b unsigned for MULHSU, and both unsigned for MULHU.
REQ-023 SHALL truncate signed quotients toward zero and give the remainder the dividend's sign.
REQ-024 SHALL, when b==0 and RISCV_DIV0=1, return all-ones for DIV/DIVU and a for REM/REMU.
REQ-025 SHALL, when b==0 and RISCV_DIV0=0, return {1,0...} for all four divide ops.
REQ-026 SHALL, when DIV/REM has a = signed minimum and b = -1 and RISCV_DIV0=1, return a for DIV and 0 for REM.
REQ-027 SHALL handle unlisted opcodes as a short path returning 0.
REQ-028 SHALL route the short-path cases of REQ-024..027 IDLE->DONE directly, so out_valid rises 1 cycle after acceptance.
REQ-029 SHALL hold result and zero stable in DONE while out_ready is low, with no timeout.
REQ-030 SHALL, in DONE with out_ready high, go to IDLE next cycle; in_ready is not asserted in the same cycle, so the minimum gap between accepts is 1 idle cycle.
REQ-031 SHALL make flush, when high in BUSY or DONE, force IDLE next cycle and discard the result; flush in IDLE blocks acceptance that cycle; flush has priority over in_valid and out_ready.
REQ-032 SHALL wrap the iteration counter only on re-acceptance; the counter is ceil(log2(XLEN+1)) bits wide.

Reset
REQ-033 SHALL, with rst high at a clock edge, set state=IDLE, counter=0, result=0, zero=1 and out_valid=0 (in_ready=1 after reset).
REQ-034 SHALL have rst take priority over flush and handshakes, and abort any in-flight op with no late out_valid.

Verification
REQ-035 SHALL pass: MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, zero=0, out_valid 33 cycles after accept.
REQ-036 SHALL pass: MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> result 0x00000000, zero=1.
REQ-037 SHALL pass: DIV a=0xFFFFFFF9 (-7), b=2 -> result 0xFFFFFFFD; REM same operands -> result 0xFFFFFFFF.
REQ-038 SHALL pass: DIVU a=5, b=0 -> result 0xFFFFFFFF and REMU -> result 5, each 1 cycle after accept; with RISCV_DIV0=0 -> result 0x80000000.
REQ-039 SHALL pass: DIV a=0x80000000, b=0xFFFFFFFF -> result 0x80000000; REM -> result 0, zero=1.
REQ-040 SHALL pass: out_ready low 5 cycles in DONE -> result held; flush at BUSY cycle 10 -> IDLE next cycle, in_ready=1, no out_valid; rst at BUSY cycle 5 -> same.
